// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: byte-masked store/load with LATENCY wait states.
// Response arrives 1+LATENCY cycles after accept; busy stalls the pipeline from the request cycle until RESP.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic [31:0] rsp_rdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_commit;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic          w_err;
  logic [AW-1:0] w_idx;

  assign w_accept = (r_state == S_IDLE) & req_valid;
  // With LATENCY=0 the commit happens on the accept edge, so the live bus is used instead of the capture.
  assign w_we     = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_addr   = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_wdata  = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_be     = (r_state == S_IDLE) ? req_be    : r_be;
  assign w_idx    = w_addr[AW+1:2];
  assign w_err    = (w_addr[1:0] != 2'b00) | (w_addr[31:AW+2] != '0);
  assign w_commit = reset & (((r_state == S_WAIT) && (r_cnt == 4'd0)) ||
                             (w_accept && (LATENCY == 0)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_be      <= 4'd0;
      r_err     <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_err <= w_err;
        if (w_err)      rsp_rdata <= 32'd0;
        else if (!w_we) rsp_rdata <= r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && !w_err && w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    busy      = reset & (w_accept | (r_state == S_WAIT));
    rsp_valid = (r_state == S_RESP);
    rsp_err   = (r_state == S_RESP) & r_err;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance and one LATENCY=0 instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        v0 = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;

  logic [31:0] rdata2, rdata0;
  logic        vld2, vld0, err2, err0, busy2, busy0;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_rdata(rdata2), .rsp_valid(vld2), .rsp_err(err2), .busy(busy2)
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_rdata(rdata0), .rsp_valid(vld0), .rsp_err(err0), .busy(busy0)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one request and records busy cycles, response cycle (-1 on timeout), data and error.
  task automatic access(input bit sel0, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int busy_cyc, output int rsp_cyc,
                        output logic [31:0] rdata, output logic err);
    busy_cyc = 0;
    rsp_cyc  = -1;
    rdata    = 'x;
    err      = 1'bx;
    @(posedge clk); #1;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    if (sel0) v0 = 1'b1; else req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sel0 ? busy0 : busy2) busy_cyc++;
      if (sel0 ? vld0 : vld2) begin
        rsp_cyc = c;
        rdata   = sel0 ? rdata0 : rdata2;
        err     = sel0 ? err0 : err2;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    v0 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (busy2 !== 1'b0 || vld2 !== 1'b0 || rdata2 !== 32'd0 || err2 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: busy=%b rsp_valid=%b rsp_err=%b rsp_rdata=%h, expected 0 0 0 00000000",
                 busy2, vld2, err2, rdata2);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy2 !== 1'b0 || vld2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b rsp_valid=%b, expected 0 0", busy2, vld2);
    end
  endtask

  task automatic test_store_load();
    int b, r; logic [31:0] d; logic e;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, b, r, d, e); idle();
    n_tests++;
    if (b !== 3 || r !== 3 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL store_timing: busy_cycles=%0d rsp_cycle=%0d err=%b, expected 3 3 0", b, r, e);
    end
    access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, b, r, d, e); idle();
    n_tests++;
    if (r !== 3 || d !== 32'hDEADBEEF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL load_after_store: rsp_cycle=%0d rdata=%h err=%b, expected 3 deadbeef 0", r, d, e);
    end
  endtask

  task automatic test_partial_store();
    int b, r; logic [31:0] d; logic e;
    access(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0010, b, r, d, e); idle();
    n_tests++;
    if (r !== 3 || d !== 32'hDEADBEEF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL store_keeps_rdata: rsp_cycle=%0d rdata=%h err=%b, expected 3 deadbeef 0", r, d, e);
    end
    access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, b, r, d, e); idle();
    n_tests++;
    if (d !== 32'hDEAD33EF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_store: rdata=%h err=%b, expected dead33ef 0", d, e);
    end
  endtask

  task automatic test_be_zero();
    int b, r; logic [31:0] d; logic e;
    access(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, b, r, d, e); idle();
    n_tests++;
    if (r !== 3 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL be_zero_complete: rsp_cycle=%0d err=%b, expected 3 0", r, e);
    end
    access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, b, r, d, e); idle();
    n_tests++;
    if (d !== 32'hDEAD33EF) begin
      n_fail++;
      $display("FAIL be_zero_unchanged: rdata=%h, expected dead33ef", d);
    end
  endtask

  task automatic test_misaligned();
    int b, r; logic [31:0] d; logic e;
    access(1'b0, 1'b0, 32'h12, 32'h0, 4'h0, b, r, d, e); idle();
    n_tests++;
    if (r !== 3 || e !== 1'b1 || d !== 32'd0) begin
      n_fail++;
      $display("FAIL misaligned: rsp_cycle=%0d err=%b rdata=%h, expected 3 1 00000000", r, e, d);
    end
  endtask

  task automatic test_out_of_range();
    int b, r; logic [31:0] d; logic e;
    access(1'b0, 1'b1, 32'hFC, 32'h0BADF00D, 4'hF, b, r, d, e); idle();
    access(1'b0, 1'b0, 32'hFC, 32'h0, 4'h0, b, r, d, e); idle();
    n_tests++;
    if (d !== 32'h0BADF00D || e !== 1'b0) begin
      n_fail++;
      $display("FAIL last_word: rdata=%h err=%b, expected 0badf00d 0", d, e);
    end
    access(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, b, r, d, e); idle();
    n_tests++;
    if (r !== 3 || e !== 1'b1 || d !== 32'd0) begin
      n_fail++;
      $display("FAIL out_of_range: rsp_cycle=%0d err=%b rdata=%h, expected 3 1 00000000", r, e, d);
    end
    access(1'b0, 1'b0, 32'hFC, 32'h0, 4'h0, b, r, d, e); idle();
    n_tests++;
    if (d !== 32'h0BADF00D || e !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_no_alias: rdata=%h err=%b, expected 0badf00d 0", d, e);
    end
  endtask

  task automatic test_reset_abort();
    int b, r; logic [31:0] d; logic e;
    int seen;
    access(1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF, b, r, d, e); idle();
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF; req_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_accept_busy: busy=%b, expected 1", busy2);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_tests++;
    if (busy2 !== 1'b0 || vld2 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy_drop: busy=%b rsp_valid=%b, expected 0 0", busy2, vld2);
    end
    req_valid = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (vld2 !== 1'b0) seen++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (vld2 !== 1'b0) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_rsp: rsp_valid cycles=%0d, expected 0", seen);
    end
    access(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, b, r, d, e); idle();
    n_tests++;
    if (d !== 32'h12345678 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_discard: rdata=%h err=%b, expected 12345678 0", d, e);
    end
  endtask

  task automatic test_back_to_back();
    int b1, r1, b2, r2; logic [31:0] d1, d2; logic e1, e2;
    access(1'b1, 1'b1, 32'h4, 32'hA5A5A5A5, 4'hF, b1, r1, d1, e1);
    access(1'b1, 1'b1, 32'h8, 32'h5A5A5A5A, 4'hF, b2, r2, d2, e2); idle();
    n_tests++;
    if (b1 !== 1 || r1 !== 1 || b2 !== 1 || r2 !== 1) begin
      n_fail++;
      $display("FAIL lat0_stores: busy=%0d/%0d rsp_cycle=%0d/%0d, expected 1/1 1/1", b1, b2, r1, r2);
    end
    access(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, b1, r1, d1, e1);
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, b2, r2, d2, e2); idle();
    n_tests++;
    if (b1 !== 1 || r1 !== 1 || d1 !== 32'hA5A5A5A5 || e1 !== 1'b0) begin
      n_fail++;
      $display("FAIL lat0_load1: busy=%0d rsp_cycle=%0d rdata=%h err=%b, expected 1 1 a5a5a5a5 0", b1, r1, d1, e1);
    end
    n_tests++;
    if (b2 !== 1 || r2 !== 1 || d2 !== 32'h5A5A5A5A || e2 !== 1'b0) begin
      n_fail++;
      $display("FAIL lat0_load2: busy=%0d rsp_cycle=%0d rdata=%h err=%b, expected 1 1 5a5a5a5a 0", b2, r2, d2, e2);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_partial_store();
    test_be_zero();
    test_misaligned();
    test_out_of_range();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
